vga_ctrl: RTL

- Timing generator for the 800x480 display path, at the opposite end of the pixel interface from vga_pic.
- Runs horizontal/vertical counters and issues pix_x/pix_y requests, with a fixed lead, to the picture generator.
- Captures the returned 24-bit color and drives latency-aligned hsync, vsync, data-enable and RGB to the panel/VGA pins.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/sig_delay.sv | 43 ++++
 rtl/vga_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared display timing constants for the 800x480 pixel path.
// Both ends of the pixel interface (vga_ctrl and vga_pic) import this package.
package vga_timing_pkg;

   // Horizontal timing in pixel clocks
   localparam int H_SYNC   = 128;
   localparam int H_BP     = 88;
   localparam int H_ACTIVE = 800;
   localparam int H_FP     = 40;
   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;

   // Vertical timing in lines
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

   // First visible column and row
   localparam int HA0 = H_SYNC + H_BP;
   localparam int VA0 = V_SYNC + V_BP;

   // Counter and coordinate widths
   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;
   localparam int PIX_W   = 10;

   // RGB888 pixel width
   localparam int RGB_W = 24;

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous clear.
// Besides the final stage, one bit of the chain can be tapped at an
// intermediate depth; TAP_DEPTH=0 taps the undelayed input.
module sig_delay #(
   parameter int WIDTH     = 1,
   parameter int DEPTH     = 1,
   parameter int TAP_DEPTH = 0,
   parameter int TAP_BIT   = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             tap
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift the input one stage per clock; clear flushes every stage at once.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

   generate
      if (TAP_DEPTH == 0) begin : g_tap_input
         assign tap = din[TAP_BIT];
      end else begin : g_tap_stage
         assign tap = stage[TAP_DEPTH-1][TAP_BIT];
      end
   endgenerate

endmodule

// File: rtl/vga_ctrl.sv
// VGA/panel timing generator. Issues pixel coordinate requests PIC_LAT clocks
// ahead of display, captures the returned color and drives sync, enable and
// RGB with all outputs aligned to the same pipeline delay.
module vga_ctrl
   import vga_timing_pkg::*;
#(
   parameter int PIC_LAT  = 1,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RGB_W-1:0] color_data_in,
   output logic             pix_req,
   output logic [PIX_W-1:0] pix_x,
   output logic [PIX_W-1:0] pix_y,
   output logic             hsync,
   output logic             vsync,
   output logic             vga_de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             frame_start
);

   localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] REQ_H0 = H_CNT_W'(HA0 - PIC_LAT);
   localparam logic [H_CNT_W-1:0] REQ_H1 = H_CNT_W'(HA0 + H_ACTIVE - PIC_LAT);
   localparam logic [V_CNT_W-1:0] REQ_V0 = V_CNT_W'(VA0);
   localparam logic [V_CNT_W-1:0] REQ_V1 = V_CNT_W'(VA0 + V_ACTIVE);
   localparam logic [H_CNT_W-1:0] HS_END = H_CNT_W'(H_SYNC);
   localparam logic [V_CNT_W-1:0] VS_END = V_CNT_W'(V_SYNC);

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               raw_hs;
   logic               raw_vs;
   logic               raw_fs;
   logic [3:0]         dly_out;
   logic               req_lat;

   // Raster counters: column wraps each line, row advances on the last column.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + H_CNT_W'(1);
      end
   end

   // Request window is the active window shifted early by the picture latency.
   always_comb begin
      pix_req = (v_cnt >= REQ_V0) && (v_cnt < REQ_V1) &&
                (h_cnt >= REQ_H0) && (h_cnt < REQ_H1);
      pix_x   = pix_req ? PIX_W'(h_cnt - REQ_H0) : '0;
      pix_y   = pix_req ? (v_cnt - REQ_V0) : '0;
      raw_hs  = (h_cnt < HS_END);
      raw_vs  = (v_cnt < VS_END);
      raw_fs  = (h_cnt == '0) && (v_cnt == '0);
   end

   sig_delay #(
      .WIDTH    (4),
      .DEPTH    (PIC_LAT + 1),
      .TAP_DEPTH(PIC_LAT),
      .TAP_BIT  (0)
   ) u_delay (
      .clk  (clk),
      .clear(rst),
      .din  ({raw_hs, raw_vs, raw_fs, pix_req}),
      .dout (dly_out),
      .tap  (req_lat)
   );

   // Capture returned color only when it answers a real request.
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_rgb <= '0;
      end else begin
         vga_rgb <= req_lat ? color_data_in : '0;
      end
   end

   assign hsync       = ~(dly_out[3] ^ SYNC_POL);
   assign vsync       = ~(dly_out[2] ^ SYNC_POL);
   assign frame_start = dly_out[1];
   assign vga_de      = dly_out[0];

endmodule
